// File: rtl/bcd_display_scan.sv
// bcd_display_scan: calculator-style BCD digit entry register with a
// time-multiplexed common-cathode 7-segment display scanner.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bcd_in     BCD digit from the upstream encoder
//   bcd_valid  single-cycle strobe qualifying bcd_in
//   clear      synchronous clear of the digits and the overflow flag
//   blank_lz   1 = blank leading zeros
//   seg        registered segments {g,f,e,d,c,b,a}, active-high
//   an         registered one-hot digit enable, active-high
//   value_out  stored digits, digit 0 (LSD) in bits [3:0]
//   overflow   sticky flag: a nonzero MSD was shifted out
//   code_err   one-cycle pulse after a strobe carrying a code above 9
module bcd_display_scan #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            bcd_in,
   input  logic                  bcd_valid,
   input  logic                  clear,
   input  logic                  blank_lz,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   value_out,
   output logic                  overflow,
   output logic                  code_err
);

   localparam int unsigned VAL_W = 4 * DIGITS;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [VAL_W-1:0]  val_d;
   logic              ovf_d, err_d;
   logic [6:0]        seg_d;
   logic [DIGITS-1:0] an_d;
   logic [3:0]        cur_digit;
   logic              cur_blank;
   logic [DIGITS-1:0] zero_from;

   // Segment pattern {g..a} for a BCD digit.
   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'b0111111;
         4'd1:    glyph = 7'b0000110;
         4'd2:    glyph = 7'b1011011;
         4'd3:    glyph = 7'b1001111;
         4'd4:    glyph = 7'b1100110;
         4'd5:    glyph = 7'b1101101;
         4'd6:    glyph = 7'b1111101;
         4'd7:    glyph = 7'b0000111;
         4'd8:    glyph = 7'b1111111;
         4'd9:    glyph = 7'b1101111;
         default: glyph = 7'b0000000;
      endcase
   endfunction

   // Entry path: clear wins, then shift-in of a valid digit.
   always_comb begin
      val_d = value_out;
      ovf_d = overflow;
      err_d = bcd_valid && (bcd_in > 4'd9);
      if (clear) begin
         val_d = '0;
         ovf_d = 1'b0;
      end else if (bcd_valid && (bcd_in <= 4'd9)) begin
         val_d = {value_out[VAL_W-5:0], bcd_in};
         if (value_out[VAL_W-1 -: 4] != 4'd0) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Free-running prescaler and scan index.
   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      idx_d = idx_q;
      if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Display path: zero_from[i] is set when digits i..DIGITS-1 are all zero.
   always_comb begin
      zero_from = '0;
      zero_from[DIGITS-1] = (value_out[VAL_W-1 -: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] && (value_out[4*i +: 4] == 4'd0);
      end
      cur_digit = '0;
      cur_blank = 1'b0;
      an_d      = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_digit = value_out[4*i +: 4];
            an_d[i]   = 1'b1;
            cur_blank = blank_lz && (i != 0) && zero_from[i];
         end
      end
      seg_d = cur_blank ? 7'b0000000 : glyph(cur_digit);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_out <= '0;
         overflow  <= 1'b0;
         code_err  <= 1'b0;
         pre_q     <= '0;
         idx_q     <= '0;
         an        <= DIGITS'(1);
         seg       <= 7'b0111111;
      end else begin
         value_out <= val_d;
         overflow  <= ovf_d;
         code_err  <= err_d;
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         an        <= an_d;
         seg       <= seg_d;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan with DIGITS=4, SCAN_DIV=4.
// Entry results go through a scoreboard queue; a reference scan model
// checks an/seg on every cycle.
module tb_bcd_display_scan;

   localparam int unsigned DIGITS   = 4;
   localparam int unsigned SCAN_DIV = 4;

   logic        clk;
   logic        rst;
   logic [3:0]  bcd_in;
   logic        bcd_valid;
   logic        clear;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] value_out;
   logic        overflow;
   logic        code_err;

   bcd_display_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .bcd_in    (bcd_in),
      .bcd_valid (bcd_valid),
      .clear     (clear),
      .blank_lz  (blank_lz),
      .seg       (seg),
      .an        (an),
      .value_out (value_out),
      .overflow  (overflow),
      .code_err  (code_err)
   );

   typedef struct {
      logic        valid;
      logic        clr;
      logic [3:0]  din;
      logic [15:0] val;
      logic        ovf;
      logic        err;
   } vec_t;

   typedef struct {
      logic [15:0] val;
      logic        ovf;
      logic        err;
   } exp_t;

   localparam int NVEC = 19;

   vec_t        vecs [NVEC];
   exp_t        sbq [$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_val;
   logic        m_ovf;
   int          m_pre;
   int          m_idx;
   logic        mon_en;
   logic [3:0]  mon_an;
   logic [6:0]  mon_seg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   // Expected segments for scan position idx showing value v.
   function automatic logic [6:0] exp_seg(input int idx, input logic [15:0] v, input logic blz);
      logic [15:0] hi;
      hi = v >> (4 * idx);
      if (blz && (idx != 0) && (hi == 16'h0000)) return 7'b0000000;
      return glyph(hi[3:0]);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference scan model: predicts an/seg from the pre-edge state.
   always @(posedge clk) begin
      if (rst) begin
         mon_an  = 4'b0001;
         mon_seg = 7'b0111111;
         m_pre   = 0;
         m_idx   = 0;
      end else begin
         mon_an  = 4'b0001 << m_idx;
         mon_seg = exp_seg(m_idx, m_val, blank_lz);
         if (m_pre == SCAN_DIV - 1) begin
            m_pre = 0;
            m_idx = (m_idx + 1) % DIGITS;
         end else begin
            m_pre = m_pre + 1;
         end
      end
      #1;
      if (mon_en) begin
         check("an", 32'(an), 32'(mon_an));
         check("seg", 32'(seg), 32'(mon_seg));
      end
   end

   // Drive one cycle of entry stimulus and score the registered result.
   task automatic apply(input logic v, input logic c, input logic [3:0] d,
                        input logic [15:0] ev, input logic eo, input logic ee);
      exp_t e;
      bcd_valid = v;
      clear     = c;
      bcd_in    = d;
      sbq.push_back('{ev, eo, ee});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check("value_out", 32'(value_out), 32'(e.val));
      check("overflow", 32'(overflow), 32'(e.ovf));
      check("code_err", 32'(code_err), 32'(e.err));
      m_val     = e.val;
      m_ovf     = e.ovf;
      bcd_valid = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 4'd0, m_val, m_ovf, 1'b0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_value"}, 32'(value_out), 32'h0);
      check({tag, "_ovf"}, 32'(overflow), 32'h0);
      check({tag, "_err"}, 32'(code_err), 32'h0);
      check({tag, "_an"}, 32'(an), 32'h1);
      check({tag, "_seg"}, 32'(seg), 32'b0111111);
   endtask

   initial begin
      rst       = 1'b1;
      bcd_valid = 1'b0;
      clear     = 1'b0;
      bcd_in    = 4'd0;
      blank_lz  = 1'b0;
      m_val     = 16'h0000;
      m_ovf     = 1'b0;
      m_pre     = 0;
      m_idx     = 0;
      mon_en    = 1'b1;

      //            valid clr   din    value      ovf   err
      vecs[0]  = '{1'b1, 1'b0, 4'd1, 16'h0001, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 4'd2, 16'h0012, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'd3, 16'h0123, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 4'd4, 16'h1234, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'd8, 16'h1234, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 4'd5, 16'h2345, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 4'd6, 16'h3456, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 4'd7, 16'h0000, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 4'd4, 16'h0004, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 4'd2, 16'h0042, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 4'hB, 16'h0042, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 4'd0, 16'h0042, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 4'd0, 16'h0420, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 4'd0, 16'h4200, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 4'd9, 16'h2009, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 4'hC, 16'h0000, 1'b0, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 4'hF, 16'h0000, 1'b0, 1'b1};
      vecs[17] = '{1'b1, 1'b0, 4'd4, 16'h0004, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 4'd2, 16'h0042, 1'b0, 1'b0};

      // Power-on reset, two cycles.
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("reset");

      // Scan rotation with value 0 and no blanking.
      idle(16);

      // Entry, overflow, clear and invalid-code vectors.
      for (int i = 0; i < NVEC; i++) begin
         apply(vecs[i].valid, vecs[i].clr, vecs[i].din, vecs[i].val, vecs[i].ovf, vecs[i].err);
      end

      // Leading-zero blanking on 0042, then on 0000, then disabled.
      blank_lz = 1'b1;
      idle(16);
      apply(1'b0, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b0);
      idle(16);
      blank_lz = 1'b0;
      idle(16);

      // Reset in the middle of a scan period with 9876 stored.
      apply(1'b1, 1'b0, 4'd9, 16'h0009, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 4'd8, 16'h0098, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 4'd7, 16'h0987, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 4'd6, 16'h9876, 1'b0, 1'b0);
      idle(2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      m_val = 16'h0000;
      m_ovf = 1'b0;
      check_reset_state("midrst");
      idle(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
Sequential consumer of 4-bit BCD digits from the decimal-to-BCD encoder stage.
- Shifts each valid digit into a DIGITS-wide entry register, calculator-style: the new digit enters the least-significant position.
- Time-multiplexes the stored digits onto a common-cathode 7-segment display, with optional leading-zero blanking.
- Flags invalid codes and digit overflow.

Parameters:
- DIGITS, 4, number of stored and displayed digits (2..8).
- SCAN_DIV, 1000, clock cycles each digit stays lit (>=2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- bcd_in  input  4  BCD digit from upstream encoder.
- bcd_valid  input  1  single-cycle strobe; bcd_in is sampled when high.
- clear  input  1  synchronous clear of the digits and the overflow flag.
- blank_lz  input  1  1 = blank leading zeros.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- an  output  DIGITS  one-hot digit enable, active-high, registered.
- value_out  output  4*DIGITS  stored digits; digit 0 (LSD) is in bits [3:0].
- overflow  output  1  sticky: a nonzero MSD was shifted out.
- code_err  output  1  one-cycle pulse: bcd_valid was high with bcd_in > 9.

Behaviour:
- Reset (rst=1 at an edge):
  - all digits, overflow, code_err, prescaler and scan index go to 0.
  - an = 1 (only digit 0 enabled); seg = 7'b0111111 (glyph "0").
  - rst overrides every other input.
- Entry, evaluated each edge:
  - clear=1 has priority: digits = 0 and overflow = 0. bcd_valid is ignored that cycle; code_err is still generated if bcd_in > 9.
  - Otherwise, bcd_valid=1 with bcd_in <= 9:
    - digit[i] <= digit[i-1] for i = DIGITS-1 down to 1; digit[0] <= bcd_in.
    - If the old digit[DIGITS-1] != 0, overflow <= 1. The lost MSD is discarded.
  - bcd_valid=1 with bcd_in > 9: digits unchanged, code_err=1 for exactly the next cycle.
  - code_err is 0 in every other cycle.
  - value_out updates on the same edge as the digits; latency is 1 cycle from the strobe.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and runs continuously, independent of entry and clear.
  - When the prescaler equals SCAN_DIV-1, it wraps to 0 and the scan index increments. The index wraps from DIGITS-1 to 0.
- Output registers, updated every edge from the pre-edge state:
  - an <= onehot(index).
  - seg <= glyph(digit[index]), or 0 if that digit is blanked.
  - So seg and an lag the index and digit state by one cycle.
- Leading-zero blanking:
  - A digit is blanked when blank_lz=1, index > 0, and every digit at positions >= index is 0.
  - Digit 0 is never blanked, so value 0 shows as a single "0".
- Glyph table {g..a}:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Stored digits are always <= 9, so no other codes occur.
- Simultaneous scan advance and entry on the same edge: both take effect. The next seg shows the new index with the new digit data one cycle later. No glitch combination is permitted: an is always exactly one-hot.
- Asserting rst mid-scan or mid-entry restores the reset state on that edge. The prescaler restarts at 0.

Test Plan:
All cases run with DIGITS=4 and SCAN_DIV=4.
- Reset: hold rst 2 cycles, release → an=0001, seg=0111111, value_out=16'h0000, overflow=0, code_err=0. an advances 0001→0010→0100→1000→0001, changing every 4 cycles.
- Entry: strobe 1,2,3,4 on consecutive cycles → value_out=16'h1234 one cycle after the last strobe. When an=0001, seg=1100110 ("4"); when an=1000, seg=0000110 ("1").
- Overflow and clear:
  - From 16'h1234, strobe 5 → value_out=16'h2345, overflow=1.
  - Strobe 6 → 16'h3456, overflow stays 1.
  - clear=1 together with bcd_valid=1 and bcd_in=7 → value_out=16'h0000, overflow=0.
- Invalid code: from 16'h0042, strobe bcd_in=4'hB → value_out stays 16'h0042; code_err high exactly 1 cycle.
- Leading-zero blanking: with value_out=16'h0042 and blank_lz=1 → seg=0000000 when an=1000 or an=0100; seg=1100110 at an=0010; seg=1011011 at an=0001. With value 16'h0000 → only an=0001 shows 0111111. With blank_lz=0 → all four digits lit.
- Reset mid-operation: assert rst during the middle of a scan period with value 16'h9876 → the next cycle gives value_out=0, an=0001, seg=0111111. The first index advance occurs 4 cycles after rst is released.
